// File: rtl/capture_ctrl.sv
// capture_ctrl: paces decimated sample writes into the trace RAM, keeps a
// circular pre-trigger window, stores a programmable post-trigger tail and
// reports the last written address until the dump stage releases it.
module capture_ctrl #(
  parameter int DEPTH = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [8:0] trig_pos,
  input  logic [3:0] decimator,
  input  logic       triggered,
  input  logic       dump_done,
  output logic       we,
  output logic       cap_en,
  output logic [8:0] cap_addr,
  output logic [8:0] trace_end,
  output logic       armed,
  output logic       capture_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] dec_cnt_reg, dec_cnt_next;
  logic [3:0]  dec_sel_reg, dec_sel_next;
  logic [8:0]  trig_pos_reg, trig_pos_next;
  logic [8:0]  addr_reg, addr_next;
  logic [9:0]  sample_cnt_reg, sample_cnt_next;
  logic [8:0]  post_cnt_reg, post_cnt_next;
  logic        we_reg, we_next;
  logic [8:0]  cap_addr_reg, cap_addr_next;
  logic [8:0]  trace_end_reg, trace_end_next;
  logic        armed_reg, armed_next;
  logic        done_reg, done_next;

  logic        tick;
  logic [9:0]  pre_target;

  // A tick fires when the decimation counter reaches 2^d - 1; the write it
  // produces appears on the following cycle.
  assign tick       = (dec_cnt_reg == ((16'd1 << dec_sel_reg) - 16'd1));
  // Number of pre-trigger writes needed before arming (512 when trig_pos=0).
  assign pre_target = 10'(DEPTH) - {1'b0, trig_pos_reg};

  // Next-state and next-output logic for the capture sequencer.
  always_comb begin
    state_next      = state_reg;
    dec_cnt_next    = dec_cnt_reg;
    dec_sel_next    = dec_sel_reg;
    trig_pos_next   = trig_pos_reg;
    addr_next       = addr_reg;
    sample_cnt_next = sample_cnt_reg;
    post_cnt_next   = post_cnt_reg;
    we_next         = 1'b0;
    cap_addr_next   = cap_addr_reg;
    trace_end_next  = trace_end_reg;

    case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next      = S_PRE;
          trig_pos_next   = trig_pos;
          dec_sel_next    = decimator;
          addr_next       = '0;
          sample_cnt_next = '0;
          dec_cnt_next    = '0;
          post_cnt_next   = '0;
        end
      end

      S_PRE, S_ARMED, S_POST: begin
        if (!run) begin
          // Abort: drop any pending write, keep the previous trace_end.
          state_next = S_IDLE;
        end else begin
          case (state_reg)
            S_PRE: begin
              if (we_reg) begin
                sample_cnt_next = sample_cnt_reg + 10'd1;
                if (sample_cnt_reg + 10'd1 == pre_target) begin
                  state_next = S_ARMED;
                end
              end
            end
            S_ARMED: begin
              // A write presented in the trigger cycle belongs to the
              // pre-trigger window, so cap_addr_reg is the newest sample.
              if (triggered) begin
                if (trig_pos_reg == 9'd0) begin
                  state_next     = S_DONE;
                  trace_end_next = cap_addr_reg;
                end else begin
                  state_next    = S_POST;
                  post_cnt_next = '0;
                end
              end
            end
            default: begin
              if (we_reg) begin
                post_cnt_next = post_cnt_reg + 9'd1;
                if (post_cnt_reg + 9'd1 == trig_pos_reg) begin
                  state_next     = S_DONE;
                  trace_end_next = cap_addr_reg;
                end
              end
            end
          endcase

          dec_cnt_next = tick ? 16'd0 : dec_cnt_reg + 16'd1;

          // No write is issued once the capture has completed.
          if (tick && (state_next != S_DONE)) begin
            we_next       = 1'b1;
            cap_addr_next = addr_reg;
            addr_next     = addr_reg + 9'd1;
          end
        end
      end

      S_DONE: begin
        if (dump_done) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    armed_next = (state_next == S_ARMED);
    done_next  = (state_next == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      dec_cnt_reg    <= '0;
      dec_sel_reg    <= '0;
      trig_pos_reg   <= '0;
      addr_reg       <= '0;
      sample_cnt_reg <= '0;
      post_cnt_reg   <= '0;
      we_reg         <= 1'b0;
      cap_addr_reg   <= '0;
      trace_end_reg  <= '0;
      armed_reg      <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dec_cnt_reg    <= dec_cnt_next;
      dec_sel_reg    <= dec_sel_next;
      trig_pos_reg   <= trig_pos_next;
      addr_reg       <= addr_next;
      sample_cnt_reg <= sample_cnt_next;
      post_cnt_reg   <= post_cnt_next;
      we_reg         <= we_next;
      cap_addr_reg   <= cap_addr_next;
      trace_end_reg  <= trace_end_next;
      armed_reg      <= armed_next;
      done_reg       <= done_next;
    end
  end

  assign we           = we_reg;
  assign cap_en       = we_reg;
  assign cap_addr     = cap_addr_reg;
  assign trace_end    = trace_end_reg;
  assign armed        = armed_reg;
  assign capture_done = done_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: stimulus pushes expected write
// addresses, arming counts and completion results; a monitor pops them as
// the DUT presents writes, armed rises and capture_done rises.
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [8:0] trig_pos = '0;
  logic [3:0] decimator = '0;
  logic       triggered = 1'b0;
  logic       dump_done = 1'b0;
  logic       we, cap_en, armed, capture_done;
  logic [8:0] cap_addr, trace_end;

  capture_ctrl #(.DEPTH(512)) dut (
    .clk(clk), .rst(rst), .run(run), .trig_pos(trig_pos),
    .decimator(decimator), .triggered(triggered), .dump_done(dump_done),
    .we(we), .cap_en(cap_en), .cap_addr(cap_addr), .trace_end(trace_end),
    .armed(armed), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int te;
    int nw;
  } done_t;

  int    exp_addr[$];
  int    exp_armed[$];
  done_t exp_done[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wcount = 0;
  int period = 1;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin
    logic armed_q, done_q;
    int   ea;
    done_t ed;
    armed_q = 1'b0;
    done_q  = 1'b0;
    forever begin
      @(negedge clk);
      if (armed && !armed_q) begin
        checks++;
        if (exp_armed.size() == 0) begin
          failures++;
          $display("FAIL armed_unexpected actual_writes=%0d required=none", wcount);
        end else begin
          ea = exp_armed.pop_front();
          if (wcount != ea) begin
            failures++;
            $display("FAIL armed_count actual=%0d required=%0d", wcount, ea);
          end
          $display("armed after %0d writes (cycle %0d)", wcount, cyc);
        end
      end
      if (capture_done && !done_q) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected actual_trace_end=%0d required=none", trace_end);
        end else begin
          ed = exp_done.pop_front();
          if (int'(trace_end) != ed.te || wcount != ed.nw) begin
            failures++;
            $display("FAIL done_result actual_trace_end=%0d actual_writes=%0d required_trace_end=%0d required_writes=%0d",
                     trace_end, wcount, ed.te, ed.nw);
          end
          $display("capture_done trace_end=%0d writes=%0d", trace_end, wcount);
        end
      end
      if (we) begin
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected actual_addr=%0d required=none", cap_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (int'(cap_addr) != ea || cap_en !== 1'b1) begin
            failures++;
            $display("FAIL write actual_addr=%0d actual_cap_en=%0b required_addr=%0d required_cap_en=1",
                     cap_addr, cap_en, ea);
          end
        end
        if (wcount > 0) begin
          checks++;
          if (cyc - last_cyc != period) begin
            failures++;
            $display("FAIL write_spacing actual=%0d required=%0d", cyc - last_cyc, period);
          end
        end
        wcount++;
        last_cyc = cyc;
      end
      armed_q = armed;
      done_q  = capture_done;
    end
  end

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(i % 512);
  endtask

  task automatic push_done(input int te, input int nw);
    done_t d;
    d.te = te;
    d.nw = nw;
    exp_done.push_back(d);
  endtask

  task automatic start_cap(input int tp, input int d);
    wcount    = 0;
    trig_pos  = 9'(tp);
    decimator = 4'(d);
    period    = 1 << d;
    run       = 1'b1;
    $display("start capture trig_pos=%0d decimator=%0d", tp, d);
  endtask

  task automatic wait_armed(input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (armed) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL armed_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_done(input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (capture_done) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  task automatic finish_dump();
    run       = 1'b0;
    triggered = 1'b0;
    dump_done = 1'b1;
    @(negedge clk);
    dump_done = 1'b0;
    check_val("done_fall", int'(capture_done), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_val(name, int'({we, cap_en, cap_addr, trace_end, armed, capture_done}), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // 1: d=0, trig_pos=100, trigger 50 cycles after armed.
    push_writes(563); exp_armed.push_back(412); push_done(50, 563);
    start_cap(100, 0);
    wait_armed(2000);
    repeat (50) @(negedge clk);
    triggered = 1'b1;
    wait_done(2000);
    finish_dump();

    // 2: d=3, trig_pos=8, trigger right after arming.
    push_writes(512); exp_armed.push_back(504); push_done(511, 512);
    start_cap(8, 3);
    wait_armed(6000);
    triggered = 1'b1;
    wait_done(2000);
    finish_dump();

    // 3: trig_pos=0 with triggered held from the start (ignored in PRE).
    push_writes(512); exp_armed.push_back(512); push_done(511, 512);
    triggered = 1'b1;
    start_cap(0, 1);
    wait_armed(3000);
    @(negedge clk);
    check_val("tp0_done_next_cycle", int'(capture_done), 1);
    check_val("tp0_trace_end", int'(trace_end), 511);
    finish_dump();

    // 4: wrap-around, trig_pos=300, trigger late in ARMED.
    push_writes(913); exp_armed.push_back(212); push_done(400, 913);
    start_cap(300, 0);
    wait_armed(2000);
    repeat (400) @(negedge clk);
    triggered = 1'b1;
    wait_done(2000);
    finish_dump();

    // 5: run dropped mid-POST after 20 post-trigger writes.
    push_writes(433); exp_armed.push_back(412);
    start_cap(100, 0);
    wait_armed(2000);
    triggered = 1'b1;
    repeat (20) @(negedge clk);
    run       = 1'b0;
    triggered = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_done_low", int'(capture_done), 0);
    check_val("abort_trace_end_kept", int'(trace_end), 400);
    check_val("abort_armed_low", int'(armed), 0);

    // 6: reset during ARMED, then a capture restarted by dump_done with run=1.
    push_writes(413); exp_armed.push_back(412);
    start_cap(100, 0);
    wait_armed(2000);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_in_armed");
    rst = 1'b0;
    @(negedge clk);
    push_writes(513); exp_armed.push_back(1); push_done(0, 513);
    start_cap(511, 0);
    wait_armed(100);
    triggered = 1'b1;
    wait_done(2000);
    triggered = 1'b0;
    wcount    = 0;
    push_writes(3); exp_armed.push_back(1);
    dump_done = 1'b1;
    @(negedge clk);
    dump_done = 1'b0;
    check_val("restart_done_fall", int'(capture_done), 0);
    repeat (4) @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);
    check_val("restart_writes", wcount, 3);

    check_val("pending_writes", exp_addr.size(), 0);
    check_val("pending_armed", exp_armed.size(), 0);
    check_val("pending_done", exp_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture-side controller that fills the 512-entry per-channel trace RAMs ahead of the dump path. It paces sample writes by a power-of-two decimation and runs a circular pre-trigger buffer. After the trigger it stores a programmable number of post-trigger samples, then reports `trace_end` and holds until the dump path signals completion. Its outputs `we`, `cap_en`, `cap_addr` and `trace_end` feed the RAM interface/dump stage directly.

## Interface
- `DEPTH`, 512: trace RAM entries; addresses are 9 bits and wrap modulo `DEPTH`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high; one clock, `clk`.
- `run`  in  1  level. High in IDLE starts a capture. Low during any capture state aborts it.
- `trig_pos`  in  9  post-trigger sample count, 0..511; latched when a capture starts.
- `decimator`  in  4  write period is 2^`decimator` clocks, 0..15; latched when a capture starts.
- `triggered`  in  1  trigger qualifier from the trigger logic; level-sampled every cycle.
- `dump_done`  in  1  one-cycle pulse from the dump stage; releases DONE.
- `we`  out  1  RAM write strobe, one cycle per sample.
- `cap_en`  out  1  RAM enable for capture; equal to `we`.
- `cap_addr`  out  9  write address, valid while `we`=1.
- `trace_end`  out  9  address of the last sample written in the completed capture.
- `armed`  out  1  high once the pre-trigger region is filled (ARMED state only).
- `capture_done`  out  1  high in DONE.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE. All outputs are registered.
- Reset values: state IDLE; `we`, `cap_en`, `armed` and `capture_done` are 0; `cap_addr` and `trace_end` are 0; all internal counters are 0.
- IDLE → PRE when `run`=1. On this transition:
  - latch `trig_pos` and `decimator`;
  - clear the address counter, sample counter and decimation counter.
- Decimation counter: 16 bits. It runs in PRE, ARMED and POST. A tick occurs when it equals 2^d−1, and the counter then clears. Each tick produces a write on the next cycle:
  - `we`=`cap_en`=1 for one cycle at the current address;
  - the address then increments modulo 512.
- PRE: counts writes. PRE → ARMED on the write that brings the count to `DEPTH`−`trig_pos`. `armed` goes high with the state.
  - With `trig_pos`=0, all 512 entries are pre-filled before ARMED.
- In PRE, `triggered` is ignored.
- ARMED: writes continue circularly and overwrite the oldest samples. On the first cycle with `triggered`=1:
  - if `trig_pos`=0: go to DONE; `trace_end` = address of the most recent write;
  - otherwise: go to POST and clear the post counter.
  - A write strobe issued in the same cycle as the trigger counts as pre-trigger.
- POST: counts writes. On the `trig_pos`-th write, latch `trace_end` = that write's address and go to DONE. `triggered` is ignored in POST.
- DONE: no writes; `trace_end` holds. On `dump_done`, go to IDLE. If `run` is still high, a new capture starts from IDLE on the following edge.
- `run`=0 in PRE, ARMED or POST: go to IDLE next edge, suppress any pending write, leave `trace_end` unchanged, and do not assert `capture_done`.
- `run` is ignored in DONE.
- `dump_done` outside DONE is ignored.
- `rst` takes priority over every other event in the same cycle.

## Timing
- `run` seen in IDLE at edge N → state PRE from N+1. The first `we` comes 2^d cycles after entering PRE; with d=0 that is cycle N+2.
- With d=0, writes are back-to-back. With d=k, successive writes are exactly 2^k cycles apart, including across the PRE/ARMED/POST boundaries.
- `armed` rises on the cycle after the threshold write.
- `capture_done` rises on the cycle after the final post-trigger write.
- With `trig_pos`=0, `capture_done` rises on the cycle after `triggered` is seen.
- `trace_end` is valid when `capture_done` is first high.
- After `dump_done`, `capture_done` falls on the next cycle.
- `rst` asserted at any edge: all outputs take reset values on that edge. There is no partial completion.

## Test plan
- `decimator`=0, `trig_pos`=100, `triggered` high 50 cycles after `armed`:
  - `armed` rises after exactly 412 writes at addresses 0..411;
  - `trace_end` equals the address of the 100th write after the trigger;
  - no gaps between writes.
- `decimator`=3, `trig_pos`=8: `we` pulses exactly 8 cycles apart; `armed` after 504 writes; exactly 8 writes after the trigger before `capture_done`.
- `trig_pos`=0, `triggered` held high from start:
  - no DONE before 512 writes;
  - trigger is ignored in PRE;
  - on the cycle after ARMED is entered, `capture_done`=1 with `trace_end`=511.
- Wrap-around: `trig_pos`=300 and a trigger late in ARMED. `cap_addr` rolls 511→0, and `trace_end` = (last address + 300 writes) mod 512.
- `run` dropped mid-POST: no further `we`; `capture_done` stays 0; `trace_end` keeps its previous value.
- `rst` pulsed during ARMED, then `dump_done` pulsed in DONE with `run`=1:
  - reset returns all outputs to 0;
  - DONE → IDLE → PRE, and the restarted capture begins writing at `cap_addr`=0.
